// File: rtl/fxp_pkg.sv
// Shared constants and width helpers for the fixed-point multiplier slice.
//   RND_*    : rounding-mode encodings carried alongside each operand pair
//   prod_w   : full-precision product width for Q(I1,F1) x Q(I2,F2)
//   shift_d  : number of product LSBs dropped (negative means left shift)
package fxp_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;

    function automatic int prod_w(int i1, int f1, int i2, int f2);
        return i1 + f1 + i2 + f2;
    endfunction

    function automatic int shift_d(int f1, int f2, int out_f);
        return f1 + f2 - out_f;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fxp_mul_pipe_if.sv
// Operand/result bundle of fxp_mul_pipe.
//   in_*     : operand side valid/ready plus a, b, rounding mode, saturate
//   out_*    : result side valid/ready plus data and per-result flags
//   sticky_* : sticky overflow/underflow and their clear
// Vectors are plain bit containers; the multiplier interprets them as signed.
// Parameters must match the ones given to fxp_mul_pipe.
interface fxp_mul_pipe_if #(
    parameter int I1    = 3,
    parameter int F1    = 2,
    parameter int I2    = 4,
    parameter int F2    = 2,
    parameter int OUT_I = 5,
    parameter int OUT_F = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [I1+F1-1:0]       in_a;
    logic [I2+F2-1:0]       in_b;
    logic [1:0]             in_rnd;
    logic                   in_sat;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_I+OUT_F-1:0] out_data;
    logic                   out_ovf;
    logic                   out_unf;
    logic                   out_inexact;
    logic                   sticky_clr;
    logic                   sticky_ovf;
    logic                   sticky_unf;

    modport master (
        output in_valid, in_a, in_b, in_rnd, in_sat, out_ready, sticky_clr,
        input  in_ready, out_valid, out_data, out_ovf, out_unf, out_inexact,
               sticky_ovf, sticky_unf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_rnd, in_sat, out_ready, sticky_clr,
        output in_ready, out_valid, out_data, out_ovf, out_unf, out_inexact,
               sticky_ovf, sticky_unf
    );
endinterface

// File: rtl/fxp_round_sat.sv
// Combinational rescale of a full-precision product to the output format.
//   p_i       : signed product, WP bits, FP fractional bits
//   rnd_i     : rounding mode (TRUNC / HALF_UP / HALF_EVEN, 3 = TRUNC)
//   sat_i     : 1 = clamp on overflow, 0 = keep low bits (wrap)
//   data_o    : signed result, OUT_I+OUT_F bits
//   ovf_o     : rounded value outside output range
//   unf_o     : nonzero product rounded to zero
//   inexact_o : nonzero bits were dropped
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WP    = 11,
    parameter int FP    = 4,
    parameter int OUT_I = 5,
    parameter int OUT_F = 3
) (
    input  logic signed [WP-1:0]          p_i,
    input  logic [1:0]                    rnd_i,
    input  logic                          sat_i,
    output logic signed [OUT_I+OUT_F-1:0] data_o,
    output logic                          ovf_o,
    output logic                          unf_o,
    output logic                          inexact_o
);
    localparam int D   = FP - OUT_F;
    localparam int W   = OUT_I + OUT_F;
    localparam int SHL = (D < 0) ? -D : 0;
    localparam int WR  = WP + 1 + SHL;          // rounded value width
    localparam int WC  = imax(WR, W) + 1;       // common compare width

    localparam logic [W-1:0] MIN_V = W'(1) << (W - 1);
    localparam logic [W-1:0] MAX_V = ~MIN_V;

    logic signed [WC-1:0] r_c;
    logic                 inex;

    generate
        if (D > 0) begin : g_rnd
            localparam logic [D-1:0] REST_MASK = {D{1'b1}} >> 1;
            logic signed [WP:0] pe, trunc, r;
            logic [D-1:0]       dropped;
            logic               half, rest_nz, inc;

            // One extra bit so the rounding carry out of the top is kept.
            assign pe      = {p_i[WP-1], p_i};
            assign trunc   = pe >>> D;
            assign dropped = p_i[D-1:0];
            assign half    = dropped[D-1];
            assign rest_nz = |(dropped & REST_MASK);

            always_comb begin
                inc = 1'b0;
                case (rnd_i)
                    RND_HALF_UP:   inc = half;
                    // Exact tie rounds up only when the kept LSB is odd.
                    RND_HALF_EVEN: inc = half && (rest_nz || trunc[0]);
                    default:       inc = 1'b0;
                endcase
            end

            assign r    = trunc + $signed({{WP{1'b0}}, inc});
            assign r_c  = {{(WC-WP-1){r[WP]}}, r};
            assign inex = |dropped;
        end else begin : g_shl
            logic signed [WR-1:0] pe, r;

            assign pe   = {{(SHL+1){p_i[WP-1]}}, p_i};
            assign r    = pe <<< SHL;
            assign r_c  = {{(WC-WR){r[WR-1]}}, r};
            assign inex = 1'b0;
        end
    endgenerate

    // In range iff every bit from the output sign bit upward agrees.
    assign ovf_o     = !((&r_c[WC-1:W-1]) || !(|r_c[WC-1:W-1]));
    assign unf_o     = (p_i != '0) && (r_c == '0);
    assign inexact_o = inex;

    always_comb begin
        data_o = r_c[W-1:0];
        if (ovf_o && sat_i)
            data_o = r_c[WC-1] ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/fxp_mul_pipe.sv
// Three-stage signed fixed-point multiplier with rounding and saturate/wrap.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : operand/result/sticky bundle (slave side)
// Stage 1 holds operands and mode, stage 2 the full product, stage 3 the
// rescaled result and its flags. The whole pipe freezes when the result is
// not taken, so in_ready is simply "output slot free or being drained".
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int I1    = 3,
    parameter int F1    = 2,
    parameter int I2    = 4,
    parameter int F2    = 2,
    parameter int OUT_I = 5,
    parameter int OUT_F = 3
) (
    input logic         clk,
    input logic         rst,
    fxp_mul_pipe_if.slave bus
);
    localparam int WA     = I1 + F1;
    localparam int WB     = I2 + F2;
    localparam int WP     = prod_w(I1, F1, I2, F2);
    localparam int W      = OUT_I + OUT_F;
    localparam int STAGES = 3;

    logic                advance, in_fire, out_xfer;
    logic [STAGES:1]     vld_pipe_q;

    logic signed [WA-1:0] a_q;
    logic signed [WB-1:0] b_q;
    logic [1:0]           rnd1_q, rnd2_q;
    logic                 sat1_q, sat2_q;

    logic signed [WP-1:0] a_ext, b_ext, p_d, p_q;

    logic signed [W-1:0]  rs_data, data_q;
    logic                 rs_ovf, rs_unf, rs_inex;
    logic                 ovf_q, unf_q, inex_q;
    logic                 st_ovf_q, st_unf_q;

    assign advance      = !vld_pipe_q[STAGES] || bus.out_ready;
    assign in_fire      = bus.in_valid && advance;
    assign out_xfer     = vld_pipe_q[STAGES] && bus.out_ready;
    assign bus.in_ready = advance;

    // Product always fits WP bits, so a WP x WP multiply truncated to WP is exact.
    assign a_ext = {{(WP-WA){a_q[WA-1]}}, a_q};
    assign b_ext = {{(WP-WB){b_q[WB-1]}}, b_q};
    assign p_d   = a_ext * b_ext;

    fxp_round_sat #(
        .WP    (WP),
        .FP    (F1 + F2),
        .OUT_I (OUT_I),
        .OUT_F (OUT_F)
    ) u_round_sat (
        .p_i       (p_q),
        .rnd_i     (rnd2_q),
        .sat_i     (sat2_q),
        .data_o    (rs_data),
        .ovf_o     (rs_ovf),
        .unf_o     (rs_unf),
        .inexact_o (rs_inex)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rnd1_q     <= RND_TRUNC;
            sat1_q     <= 1'b0;
            p_q        <= '0;
            rnd2_q     <= RND_TRUNC;
            sat2_q     <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inex_q     <= 1'b0;
        end else if (advance) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_fire};
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            rnd1_q     <= bus.in_rnd;
            sat1_q     <= bus.in_sat;
            p_q        <= p_d;
            rnd2_q     <= rnd1_q;
            sat2_q     <= sat1_q;
            // Bubbles leave the last result in place rather than loading junk.
            if (vld_pipe_q[STAGES-1]) begin
                data_q <= rs_data;
                ovf_q  <= rs_ovf;
                unf_q  <= rs_unf;
                inex_q <= rs_inex;
            end
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_ovf_q <= 1'b0;
            st_unf_q <= 1'b0;
        end else begin
            st_ovf_q <= (st_ovf_q && !bus.sticky_clr) || (out_xfer && ovf_q);
            st_unf_q <= (st_unf_q && !bus.sticky_clr) || (out_xfer && unf_q);
        end
    end

    assign bus.out_valid   = vld_pipe_q[STAGES];
    assign bus.out_data    = data_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_unf     = unf_q;
    assign bus.out_inexact = inex_q;
    assign bus.sticky_ovf  = st_ovf_q;
    assign bus.sticky_unf  = st_unf_q;

endmodule
